decode_exception_stage: RTL and testbench

- Single-entry decode pipeline register between the fetch unit and issue.
- Holds each fetched instruction and presents it to the illegal instruction checker.
- Legal, non-faulting instructions are forwarded to issue.
- Faulting or illegal instructions are converted into a precise exception request. The request waits for all older instructions to drain, then holds until the exception controller acknowledges and flushes.

---
 rtl/decode_exception_stage_pkg.sv | 22 ++
 rtl/decode_exception_stage_if.sv | 41 ++++
 rtl/decode_exception_stage_entry.sv | 33 +++
 rtl/decode_exception_stage.sv | 124 ++++++++++++
 tb/tb_decode_exception_stage.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_exception_stage_pkg.sv
// rtl/decode_exception_stage_pkg.sv - shared types and cause codes for the decode exception stage
package decode_exception_stage_pkg;

   localparam logic [4:0] INST_ACCESS_FAULT = 5'd1;
   localparam logic [4:0] ILLEGAL_INST      = 5'd2;
   localparam logic [4:0] INST_PAGE_FAULT   = 5'd12;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DRAIN      = 2'd1,
      REQUEST    = 2'd2,
      WAIT_FLUSH = 2'd3
   } decode_exception_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instruction;
      logic        fault;
      logic [4:0]  fault_code;
   } fetch_entry_t;

endpackage

// File: rtl/decode_exception_stage_if.sv
// rtl/decode_exception_stage_if.sv - fetch/checker/issue/exception signal bundle for the decode exception stage
interface decode_exception_stage_if #(
   parameter int COUNT_WIDTH = 32
);
   logic                   fetch_valid;
   logic                   fetch_ready;
   logic [31:0]            fetch_pc;
   logic [31:0]            fetch_instruction;
   logic                   fetch_fault;
   logic [4:0]             fetch_fault_code;
   logic [31:0]            checker_instruction;
   logic                   checker_illegal;
   logic                   issue_valid;
   logic                   issue_ready;
   logic [31:0]            issue_pc;
   logic [31:0]            issue_instruction;
   logic                   older_outstanding;
   logic                   exception_valid;
   logic                   exception_ack;
   logic [4:0]             exception_code;
   logic [31:0]            exception_pc;
   logic [31:0]            exception_tval;
   logic                   flush;
   logic [COUNT_WIDTH-1:0] illegal_count;

   // Environment side: fetch unit, illegal checker, issue, exception controller
   modport master (
      output fetch_valid, fetch_pc, fetch_instruction, fetch_fault, fetch_fault_code,
      output checker_illegal, issue_ready, older_outstanding, exception_ack, flush,
      input  fetch_ready, checker_instruction, issue_valid, issue_pc, issue_instruction,
      input  exception_valid, exception_code, exception_pc, exception_tval, illegal_count
   );

   // Stage side
   modport slave (
      input  fetch_valid, fetch_pc, fetch_instruction, fetch_fault, fetch_fault_code,
      input  checker_illegal, issue_ready, older_outstanding, exception_ack, flush,
      output fetch_ready, checker_instruction, issue_valid, issue_pc, issue_instruction,
      output exception_valid, exception_code, exception_pc, exception_tval, illegal_count
   );
endinterface

// File: rtl/decode_exception_stage_entry.sv
// rtl/decode_exception_stage_entry.sv - single decode entry register with load and clear
module decode_exception_stage_entry
   import decode_exception_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         clear_i,
   input  fetch_entry_t entry_i,
   output fetch_entry_t entry_o,
   output logic         valid_o
);

   fetch_entry_t entry_q;
   logic         valid_q;

   // Load wins over clear so an issued entry can be replaced in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         entry_q <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         entry_q <= entry_i;
         valid_q <= 1'b1;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end
   end

   assign entry_o = entry_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/decode_exception_stage.sv
// rtl/decode_exception_stage.sv - decode pipeline register turning faults/illegal instructions into precise exceptions
module decode_exception_stage
   import decode_exception_stage_pkg::*;
#(
   parameter logic [4:0] ILLEGAL_INST_CODE = ILLEGAL_INST,
   parameter int         COUNT_WIDTH       = 32
)(
   input  logic                     clk,
   input  logic                     rst,
   decode_exception_stage_if.slave  bus
);

   decode_exception_state_t state_q;
   fetch_entry_t            fetch_entry;
   fetch_entry_t            entry;
   logic                    entry_valid;
   logic                    load;
   logic                    clear;
   logic                    in_idle;
   logic                    exc;
   logic                    illegal_only;
   logic [4:0]              exc_code;
   logic [31:0]             exc_tval;
   logic                    issue_valid;
   logic                    fetch_ready;
   logic                    exception_valid_q;
   logic [4:0]              exception_code_q;
   logic [31:0]             exception_pc_q;
   logic [31:0]             exception_tval_q;
   logic [COUNT_WIDTH-1:0]  illegal_count_q;

   assign fetch_entry = '{pc:          bus.fetch_pc,
                          instruction: bus.fetch_instruction,
                          fault:       bus.fetch_fault,
                          fault_code:  bus.fetch_fault_code};

   decode_exception_stage_entry u_entry (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .clear_i (clear),
      .entry_i (fetch_entry),
      .entry_o (entry),
      .valid_o (entry_valid)
   );

   // Classify the held entry; a fetch fault outranks the checker's verdict
   always_comb begin
      exc          = entry_valid & (entry.fault | bus.checker_illegal);
      illegal_only = entry_valid & ~entry.fault & bus.checker_illegal;
      exc_code     = ILLEGAL_INST_CODE;
      exc_tval     = entry.instruction;
      if (entry.fault) begin
         exc_code = entry.fault_code;
         exc_tval = entry.pc;
      end
   end

   assign in_idle     = (state_q == IDLE);
   assign issue_valid = in_idle & entry_valid & ~exc;
   assign fetch_ready = in_idle & (~entry_valid | (issue_valid & bus.issue_ready));
   assign load        = bus.fetch_valid & fetch_ready & ~bus.flush;
   assign clear       = bus.flush | (issue_valid & bus.issue_ready);

   // Exception sequencing: capture cause, wait for older work, request, then wait for the flush
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         exception_valid_q <= 1'b0;
         exception_code_q  <= '0;
         exception_pc_q    <= '0;
         exception_tval_q  <= '0;
         illegal_count_q   <= '0;
      end else if (bus.flush) begin
         state_q           <= IDLE;
         exception_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (exc) begin
                  state_q          <= DRAIN;
                  exception_code_q <= exc_code;
                  exception_pc_q   <= entry.pc;
                  exception_tval_q <= exc_tval;
                  if (illegal_only && (illegal_count_q != '1)) begin
                     illegal_count_q <= illegal_count_q + COUNT_WIDTH'(1);
                  end
               end
            end
            DRAIN: begin
               if (!bus.older_outstanding) begin
                  state_q           <= REQUEST;
                  exception_valid_q <= 1'b1;
               end
            end
            REQUEST: begin
               if (bus.exception_ack) begin
                  state_q           <= WAIT_FLUSH;
                  exception_valid_q <= 1'b0;
               end
            end
            WAIT_FLUSH: begin
               state_q <= WAIT_FLUSH;
            end
            default: begin
               state_q           <= IDLE;
               exception_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fetch_ready         = fetch_ready;
   assign bus.checker_instruction = entry.instruction;
   assign bus.issue_valid         = issue_valid;
   assign bus.issue_pc            = entry.pc;
   assign bus.issue_instruction   = entry.instruction;
   assign bus.exception_valid     = exception_valid_q;
   assign bus.exception_code      = exception_code_q;
   assign bus.exception_pc        = exception_pc_q;
   assign bus.exception_tval      = exception_tval_q;
   assign bus.illegal_count       = illegal_count_q;

endmodule

// File: tb/tb_decode_exception_stage.sv
// tb/tb_decode_exception_stage.sv - vector table and scoreboard bench for decode_exception_stage
module tb_decode_exception_stage;
   import decode_exception_stage_pkg::*;

   localparam int CW = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
      logic [4:0]  fcode;
      int          older_cycles;
      int          ack_delay;
      logic        exp_exc;
      logic [4:0]  exp_code;
      logic [31:0] exp_tval;
      int          exp_count;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } iss_t;

   typedef struct {
      logic [4:0]  code;
      logic [31:0] pc;
      logic [31:0] tval;
   } exc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   t0;
   logic ev_prev  = 1'b0;
   iss_t iss_q[$];
   exc_t exc_q[$];
   iss_t e_iss;
   exc_t e_exc;
   vec_t vecs[8];

   decode_exception_stage_if #(.COUNT_WIDTH(CW)) bus ();

   decode_exception_stage #(.ILLEGAL_INST_CODE(5'd2), .COUNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Illegal-checker peer model: all-ones is the only illegal encoding used here
   assign bus.checker_illegal = (bus.checker_instruction == 32'hFFFF_FFFF);

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: issue handshakes and exception request rises
   always @(negedge clk) begin
      if (!rst) begin
         check("issue_exception_exclusive", {31'd0, bus.issue_valid & bus.exception_valid}, 32'd0);
         if (bus.issue_valid && bus.issue_ready) begin
            if (iss_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL issue_unexpected: got issue pc 0x%0h, required no issue", bus.issue_pc);
            end else begin
               e_iss = iss_q.pop_front();
               check("issue_pc", bus.issue_pc, e_iss.pc);
               check("issue_instruction", bus.issue_instruction, e_iss.instr);
            end
         end
         if (bus.exception_valid && !ev_prev) begin
            if (exc_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL exception_unexpected: got request pc 0x%0h, required none", bus.exception_pc);
            end else begin
               e_exc = exc_q.pop_front();
               check("exception_code", {27'd0, bus.exception_code}, {27'd0, e_exc.code});
               check("exception_pc", bus.exception_pc, e_exc.pc);
               check("exception_tval", bus.exception_tval, e_exc.tval);
            end
         end
      end
      ev_prev = bus.exception_valid;
   end

   // Present one fetch entry from a drive point (posedge+1) until it is accepted
   task automatic fetch(input logic [31:0] pc, input logic [31:0] instr,
                        input logic fault, input logic [4:0] fcode);
      int n;
      bus.fetch_valid       = 1'b1;
      bus.fetch_pc          = pc;
      bus.fetch_instruction = instr;
      bus.fetch_fault       = fault;
      bus.fetch_fault_code  = fcode;
      n = 0;
      @(negedge clk);
      while (!bus.fetch_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("fetch_accept_in_budget", {31'd0, n < 20}, 32'd1);
      @(posedge clk);
      #1;
      bus.fetch_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      if (!v.exp_exc) begin
         iss_q.push_back('{v.pc, v.instr});
         fetch(v.pc, v.instr, v.fault, v.fcode);
         @(negedge clk);
         check("legal_issue_valid", {31'd0, bus.issue_valid}, 32'd1);
         @(posedge clk);
         #1;
      end else begin
         bus.older_outstanding = (v.older_cycles > 0);
         exc_q.push_back('{v.exp_code, v.pc, v.exp_tval});
         fetch(v.pc, v.instr, v.fault, v.fcode);
         repeat (v.older_cycles) begin
            @(negedge clk);
            check("drain_no_request", {31'd0, bus.exception_valid}, 32'd0);
            check("drain_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
            @(posedge clk);
            #1;
         end
         bus.older_outstanding = 1'b0;
         n = 0;
         @(negedge clk);
         while (!bus.exception_valid && n < 8) begin
            n++;
            @(negedge clk);
         end
         check("request_latency", n, (v.older_cycles == 0) ? 32'd2 : 32'd1);
         @(posedge clk);
         #1;
         repeat (v.ack_delay) begin
            @(negedge clk);
            check("request_hold_valid", {31'd0, bus.exception_valid}, 32'd1);
            check("request_hold_code", {27'd0, bus.exception_code}, {27'd0, v.exp_code});
            check("request_hold_tval", bus.exception_tval, v.exp_tval);
            @(posedge clk);
            #1;
         end
         bus.exception_ack = 1'b1;
         @(posedge clk);
         #1;
         bus.exception_ack = 1'b0;
         @(negedge clk);
         check("ack_deasserts_request", {31'd0, bus.exception_valid}, 32'd0);
         check("wait_flush_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
         @(posedge clk);
         #1;
         bus.flush = 1'b1;
         @(posedge clk);
         #1;
         bus.flush = 1'b0;
         @(negedge clk);
         check("flush_idle_ready", {31'd0, bus.fetch_ready}, 32'd1);
         check("flush_no_issue", {31'd0, bus.issue_valid}, 32'd0);
         @(posedge clk);
         #1;
      end
      check("illegal_count", {30'd0, bus.illegal_count}, v.exp_count);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{32'h300, 32'h0050_0113, 1'b0, 5'd0,  0, 0, 1'b0, 5'd0,  32'h0,         0};
      vecs[1] = '{32'h200, 32'hFFFF_FFFF, 1'b0, 5'd0,  3, 2, 1'b1, 5'd2,  32'hFFFF_FFFF, 1};
      vecs[2] = '{32'h400, 32'hFFFF_FFFF, 1'b1, 5'd12, 0, 0, 1'b1, 5'd12, 32'h400,       1};
      vecs[3] = '{32'h500, 32'h0000_0013, 1'b1, 5'd1,  1, 1, 1'b1, 5'd1,  32'h500,       1};
      vecs[4] = '{32'h600, 32'hFFFF_FFFF, 1'b0, 5'd0,  0, 0, 1'b1, 5'd2,  32'hFFFF_FFFF, 2};
      vecs[5] = '{32'h604, 32'hFFFF_FFFF, 1'b0, 5'd0,  0, 0, 1'b1, 5'd2,  32'hFFFF_FFFF, 3};
      vecs[6] = '{32'h608, 32'hFFFF_FFFF, 1'b0, 5'd0,  2, 0, 1'b1, 5'd2,  32'hFFFF_FFFF, 3};
      vecs[7] = '{32'h700, 32'h0010_0093, 1'b0, 5'd0,  0, 0, 1'b0, 5'd0,  32'h0,         3};

      bus.fetch_valid       = 1'b0;
      bus.fetch_pc          = '0;
      bus.fetch_instruction = '0;
      bus.fetch_fault       = 1'b0;
      bus.fetch_fault_code  = '0;
      bus.issue_ready       = 1'b1;
      bus.older_outstanding = 1'b0;
      bus.exception_ack     = 1'b0;
      bus.flush             = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
      check("reset_exception_valid", {31'd0, bus.exception_valid}, 32'd0);
      check("reset_issue_pc", bus.issue_pc, 32'd0);
      check("reset_checker_instruction", bus.checker_instruction, 32'd0);
      check("reset_illegal_count", {30'd0, bus.illegal_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Back-to-back legal ADDIs: one accepted per cycle
      t0 = cyc;
      iss_q.push_back('{32'h100, 32'h0010_0093});
      fetch(32'h100, 32'h0010_0093, 1'b0, 5'd0);
      iss_q.push_back('{32'h104, 32'h0020_0113});
      fetch(32'h104, 32'h0020_0113, 1'b0, 5'd0);
      iss_q.push_back('{32'h108, 32'h0030_0193});
      fetch(32'h108, 32'h0030_0193, 1'b0, 5'd0);
      check("back_to_back_cycles", cyc - t0, 32'd3);
      repeat (2) @(posedge clk);
      #1;
      check("back_to_back_drained", iss_q.size(), 32'd0);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i]);
      end

      // Issue backpressure holds the entry and blocks fetch
      bus.issue_ready = 1'b0;
      iss_q.push_back('{32'h800, 32'h0040_0213});
      fetch(32'h800, 32'h0040_0213, 1'b0, 5'd0);
      iss_q.push_back('{32'h804, 32'h0050_0293});
      bus.fetch_valid       = 1'b1;
      bus.fetch_pc          = 32'h804;
      bus.fetch_instruction = 32'h0050_0293;
      repeat (4) begin
         @(negedge clk);
         check("stall_issue_valid", {31'd0, bus.issue_valid}, 32'd1);
         check("stall_issue_pc", bus.issue_pc, 32'h800);
         check("stall_issue_instruction", bus.issue_instruction, 32'h0040_0213);
         check("stall_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      bus.issue_ready = 1'b1;
      @(negedge clk);
      check("release_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.fetch_valid = 1'b0;
      @(negedge clk);
      check("release_next_loaded", bus.issue_pc, 32'h804);
      @(posedge clk);
      #1;

      // Flush beats a same-cycle fetch: nothing is loaded
      bus.fetch_valid       = 1'b1;
      bus.fetch_pc          = 32'h900;
      bus.fetch_instruction = 32'h0060_0313;
      bus.flush             = 1'b1;
      @(posedge clk);
      #1;
      bus.fetch_valid = 1'b0;
      bus.flush       = 1'b0;
      @(negedge clk);
      check("flush_fetch_not_loaded", {31'd0, bus.issue_valid}, 32'd0);
      check("flush_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Flush beats a same-cycle ack while in REQUEST
      exc_q.push_back('{5'd2, 32'hA00, 32'hFFFF_FFFF});
      fetch(32'hA00, 32'hFFFF_FFFF, 1'b0, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      bus.flush         = 1'b1;
      bus.exception_ack = 1'b1;
      @(negedge clk);
      check("request_before_flush", {31'd0, bus.exception_valid}, 32'd1);
      @(posedge clk);
      #1;
      bus.flush         = 1'b0;
      bus.exception_ack = 1'b0;
      @(negedge clk);
      check("request_flush_valid", {31'd0, bus.exception_valid}, 32'd0);
      check("request_flush_idle", {31'd0, bus.fetch_ready}, 32'd1);
      check("flush_keeps_count", {30'd0, bus.illegal_count}, 32'd3);
      @(posedge clk);
      #1;
      run_vec(vecs[7]);

      // Reset while draining clears everything
      bus.older_outstanding = 1'b1;
      fetch(32'hC00, 32'hFFFF_FFFF, 1'b0, 5'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_drain_exception_valid", {31'd0, bus.exception_valid}, 32'd0);
      check("rst_drain_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
      check("rst_drain_exception_pc", bus.exception_pc, 32'd0);
      check("rst_drain_exception_code", {27'd0, bus.exception_code}, 32'd0);
      check("rst_drain_issue_pc", bus.issue_pc, 32'd0);
      check("rst_drain_illegal_count", {30'd0, bus.illegal_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.older_outstanding = 1'b0;
      @(negedge clk);
      check("rst_drain_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1;

      check("issue_scoreboard_empty", iss_q.size(), 32'd0);
      check("exception_scoreboard_empty", exc_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
